spi_rx_packer: RTL and testbench

SPI_RX_PACKER -- requirements
Module: spi_rx_packer

---
 rtl/spi_rx_packer_pkg.sv | 22 ++
 rtl/spi_rx_packer_if.sv | 24 ++
 rtl/npu_sync_edge.sv | 29 ++
 rtl/spi_rx_packer.sv | 123 ++++++++++++
 tb/tb_spi_rx_packer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_rx_packer_pkg.sv
// Shared NPU line/word geometry and small helpers for the SPI receive packer.
// Everything that sizes the packer comes from here so the FIFO side stays consistent.
package spi_rx_packer_pkg;

   localparam int NPU_LINE_W      = 256;
   localparam int NPU_WORD_W      = 16;
   localparam int NPU_WORDS       = NPU_LINE_W / NPU_WORD_W;
   localparam int NPU_SYNC_STAGES = 2;
   localparam int BYTE_W          = 8;

   typedef enum logic {
      PHASE_LO = 1'b0,
      PHASE_HI = 1'b1
   } byte_phase_e;

   // LSB-first serial data lands in the MSB and walks down toward bit 0.
   function automatic logic [BYTE_W-1:0] shift_lsb_first(input logic [BYTE_W-1:0] cur,
                                                         input logic              bit_in);
      return {bit_in, cur[BYTE_W-1:1]};
   endfunction

endpackage

// File: rtl/spi_rx_packer_if.sv
// SPI pins and downstream FIFO write port of the packer, grouped as one bundle.
// The slave modport is the packer; the master modport is whatever drives it.
interface spi_rx_packer_if
   import spi_rx_packer_pkg::*;
#(
   parameter int LINE_W = NPU_LINE_W
);
   logic              spi_ss;
   logic              spi_sclk;
   logic              spi_mosi;
   logic              fifo_full;
   logic              line_wr_en;
   logic [LINE_W-1:0] line_data;

   modport master (
      output spi_ss, spi_sclk, spi_mosi, fifo_full,
      input  line_wr_en, line_data
   );

   modport slave (
      input  spi_ss, spi_sclk, spi_mosi, fifo_full,
      output line_wr_en, line_data
   );
endinterface

// File: rtl/npu_sync_edge.sv
// N-flop synchronizer for an asynchronous level, with a rising-edge pulse
// derived from the synchronized output.
module npu_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic IDLE   = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q,
   output logic rise
);
   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (clr) begin
         chain <= {STAGES{IDLE}};
         prev  <= IDLE;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
endmodule

// File: rtl/spi_rx_packer.sv
// SPI mode-0 slave receiver that assembles LSB-first bytes into 16-bit words
// and 16-word lines, writing each completed line to the downstream FIFO.
module spi_rx_packer
   import spi_rx_packer_pkg::*;
#(
   parameter int  NPU_DATA_WIDTH = NPU_LINE_W,
   parameter int  WORD_WIDTH     = NPU_WORD_W,
   parameter int  SYNC_STAGES    = NPU_SYNC_STAGES,
   localparam int WORDS_PER_LINE = NPU_DATA_WIDTH / WORD_WIDTH,
   localparam int CNT_W          = $clog2(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              soft_reset,
   spi_rx_packer_if.slave    bus,
   output logic              overflow,
   output logic [CNT_W-1:0]  word_cnt
);

   logic                      clr;
   logic                      sclk_q, sclk_rise;
   logic                      ss_q, ss_rise;
   logic [SYNC_STAGES-1:0]    mosi_sync;
   logic                      mosi_q;

   logic [2:0]                bit_cnt;
   byte_phase_e               phase;
   logic [BYTE_W-1:0]         byte_sr;
   logic [BYTE_W-1:0]         lo_byte;
   logic [WORD_WIDTH-1:0]     line_buf [WORDS_PER_LINE];
   logic [NPU_DATA_WIDTH-1:0] line_flat;
   logic                      vld_p1;
   logic                      line_wr_en_p2;
   logic [NPU_DATA_WIDTH-1:0] line_data_p2;

   logic                      bit_accept;
   logic [BYTE_W-1:0]         byte_next;
   logic                      byte_done;
   logic                      word_done;
   logic                      line_done;

   assign clr = ~reset_b | soft_reset;

   npu_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sclk (
      .clk  (clk),
      .clr  (clr),
      .d    (bus.spi_sclk),
      .q    (sclk_q),
      .rise (sclk_rise)
   );

   npu_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ss (
      .clk  (clk),
      .clr  (clr),
      .d    (bus.spi_ss),
      .q    (ss_q),
      .rise (ss_rise)
   );

   // mosi only needs the same delay as sclk so data and clock stay aligned
   always_ff @(posedge clk) begin
      if (clr) begin
         mosi_sync <= '0;
      end else begin
         mosi_sync[0] <= bus.spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];
      end
   end
   assign mosi_q = mosi_sync[SYNC_STAGES-1];

   always_comb begin
      bit_accept = sclk_rise & ~ss_q;
      byte_next  = shift_lsb_first(byte_sr, mosi_q);
      byte_done  = bit_accept && (bit_cnt == 3'd7);
      word_done  = byte_done && (phase == PHASE_HI);
      line_done  = word_done && (word_cnt == CNT_W'(WORDS_PER_LINE - 1));
   end

   // ---- stage p0: bit shift, byte/word assembly, slot insertion ----
   always_ff @(posedge clk) begin
      if (clr) begin
         bit_cnt  <= '0;
         phase    <= PHASE_LO;
         word_cnt <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= line_done;
         if (bit_accept)   bit_cnt <= bit_cnt + 3'd1;
         else if (ss_rise) bit_cnt <= '0;
         if (byte_done)    phase <= (phase == PHASE_LO) ? PHASE_HI : PHASE_LO;
         if (word_done)    word_cnt <= line_done ? '0 : word_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (bit_accept) byte_sr <= byte_next;
      if (byte_done && phase == PHASE_LO) lo_byte <= byte_next;
      if (word_done) line_buf[word_cnt] <= {byte_next, lo_byte};
   end

   always_comb begin
      line_flat = '0;
      for (int i = 0; i < WORDS_PER_LINE; i++)
         line_flat[i*WORD_WIDTH +: WORD_WIDTH] = line_buf[i];
   end

   // ---- stage p1 -> p2: FIFO write or drop of the completed line ----
   always_ff @(posedge clk) begin
      if (clr) begin
         line_wr_en_p2 <= 1'b0;
         line_data_p2  <= '0;
         overflow      <= 1'b0;
      end else begin
         line_wr_en_p2 <= vld_p1 & ~bus.fifo_full;
         if (vld_p1 && !bus.fifo_full) line_data_p2 <= line_flat;
         if (vld_p1 && bus.fifo_full)  overflow     <= 1'b1;
      end
   end

   assign bus.line_wr_en = line_wr_en_p2;
   assign bus.line_data  = line_data_p2;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Randomized bench for spi_rx_packer against a queue-based line model.
module tb_spi_rx_packer;
   import spi_rx_packer_pkg::*;

   logic       clk = 1'b0;
   logic       reset_b;
   logic       soft_reset;
   logic       overflow;
   logic [3:0] word_cnt;

   spi_rx_packer_if #(.LINE_W(NPU_LINE_W)) bus ();

   spi_rx_packer dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .soft_reset (soft_reset),
      .bus        (bus.slave),
      .overflow   (overflow),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: bytes pair into words, 16 words form a line
   logic [7:0]   m_lo;
   bit           m_hi;
   logic [15:0]  m_words[$];
   logic [255:0] exp_lines[$];
   bit           exp_ovf;
   logic [255:0] last_line;
   int           strobe_cnt;
   bit           prev_wr;

   function automatic void model_clear();
      m_hi = 1'b0;
      m_words.delete();
      exp_ovf = 1'b0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [255:0] ln;
      if (!m_hi) begin
         m_lo = b;
         m_hi = 1'b1;
      end else begin
         m_words.push_back({b, m_lo});
         m_hi = 1'b0;
         if (m_words.size() == 16) begin
            ln = '0;
            for (int i = 0; i < 16; i++) ln[i*16 +: 16] = m_words[i];
            m_words.delete();
            if (bus.fifo_full) exp_ovf = 1'b1;
            else exp_lines.push_back(ln);
         end
      end
   endfunction

   always @(negedge clk) begin
      if (bus.line_wr_en) begin
         strobe_cnt++;
         chk("pulse_width", prev_wr, 1'b0);
         chk("line_expected", exp_lines.size() > 0, 1'b1);
         if (exp_lines.size() > 0) chk("line_data", bus.line_data, exp_lines.pop_front());
         last_line = bus.line_data;
      end
      prev_wr = bus.line_wr_en;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.spi_mosi = b;
      idle(2);
      bus.spi_sclk = 1'b1;
      idle(2);
      bus.spi_sclk = 1'b0;
   endtask

   // physical byte, optionally measuring clk cycles from the last sclk rise to the strobe
   task automatic phys_byte(input logic [7:0] b, input bit measure, output int lat);
      bit seen;
      lat = 0;
      seen = 1'b0;
      bus.spi_ss = 1'b0;
      idle(2);
      for (int i = 0; i < 8; i++) begin
         if (measure && i == 7) begin
            bus.spi_mosi = b[i];
            idle(2);
            bus.spi_sclk = 1'b1;
            for (int k = 0; k < 20 && !seen; k++) begin
               @(negedge clk);
               lat++;
               seen = bus.line_wr_en;
            end
            bus.spi_sclk = 1'b0;
         end else begin
            send_bit(b[i]);
         end
      end
      idle(2);
      bus.spi_ss = 1'b1;
      idle(3);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int lat;
      model_byte(b);
      phys_byte(b, 1'b0, lat);
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic do_reset();
      reset_b = 1'b0;
      bus.spi_ss = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.fifo_full = 1'b0;
      idle(3);
      chk("rst_wr_en", bus.line_wr_en, 1'b0);
      chk("rst_line_data", bus.line_data, '0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_word_cnt", word_cnt, 4'd0);
      reset_b = 1'b1;
      model_clear();
      exp_lines.delete();
      last_line = '0;
      idle(2);
   endtask

   initial begin
      int lat;
      int s0;
      logic [7:0] b;
      strobe_cnt = 0;
      prev_wr = 1'b0;
      soft_reset = 1'b0;
      reset_b = 1'b1;
      bus.spi_ss = 1'b0;
      bus.spi_sclk = 1'b1;
      bus.spi_mosi = 1'b1;
      bus.fifo_full = 1'b0;
      model_clear();
      idle(2);
      do_reset();

      // bytes 0x00..0x1F, last bit timed
      s0 = strobe_cnt;
      for (int i = 0; i < 31; i++) send_byte(8'(i));
      model_byte(8'h1F);
      phys_byte(8'h1F, 1'b1, lat);
      chk("latency", lat, NPU_SYNC_STAGES + 2);
      chk("strobes_seq", strobe_cnt - s0, 1);
      chk("seq_word0", bus.line_data[15:0], 16'h0100);
      chk("seq_word15", bus.line_data[255:240], 16'h1F1E);
      idle(10);
      chk("hold_after_line", bus.line_data, last_line);

      // words 0..159
      s0 = strobe_cnt;
      for (int w = 0; w < 160; w++) send_word(16'(w));
      idle(4);
      chk("strobes_160", strobe_cnt - s0, 10);
      chk("word_cnt_160", word_cnt, 4'd0);
      chk("ovf_160", overflow, 1'b0);

      // full FIFO at the 16th word
      for (int w = 0; w < 15; w++) send_word(16'($urandom));
      s0 = strobe_cnt;
      bus.fifo_full = 1'b1;
      send_word(16'($urandom));
      idle(4);
      bus.fifo_full = 1'b0;
      chk("strobes_full", strobe_cnt - s0, 0);
      chk("ovf_full", overflow, exp_ovf);
      chk("word_cnt_drop", word_cnt, 4'd0);
      chk("hold_after_drop", bus.line_data, last_line);
      for (int w = 0; w < 16; w++) send_word(16'($urandom));
      idle(4);
      chk("strobes_after_full", strobe_cnt - s0, 1);
      chk("ovf_sticky", overflow, 1'b1);
      do_reset();

      // aborted partial byte, then 0xA5 0x5A
      bus.spi_ss = 1'b0;
      idle(2);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      idle(2);
      bus.spi_ss = 1'b1;
      idle(4);
      send_byte(8'hA5);
      send_byte(8'h5A);
      chk("word_cnt_abort", word_cnt, 4'(m_words.size()));
      for (int w = 0; w < 15; w++) send_word(16'($urandom));
      idle(4);
      chk("abort_slot0", bus.line_data[15:0], 16'h5AA5);

      // soft reset mid-line (7 words plus a low byte)
      for (int w = 0; w < 7; w++) send_word(16'($urandom));
      send_byte(8'($urandom));
      soft_reset = 1'b1;
      idle(2);
      soft_reset = 1'b0;
      model_clear();
      idle(2);
      chk("soft_word_cnt", word_cnt, 4'd0);
      chk("soft_line_data", bus.line_data, '0);
      s0 = strobe_cnt;
      for (int w = 0; w < 16; w++) send_word(16'hBEEF);
      idle(4);
      chk("strobes_beef", strobe_cnt - s0, 1);
      chk("beef_line", bus.line_data, {16{16'hBEEF}});

      // sclk toggling while deselected
      s0 = strobe_cnt;
      bus.spi_ss = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.spi_mosi = 1'($urandom);
         bus.spi_sclk = 1'b1;
         idle(2);
         bus.spi_sclk = 1'b0;
         idle(2);
      end
      chk("desel_word_cnt", word_cnt, 4'd0);
      chk("desel_strobes", strobe_cnt - s0, 0);
      for (int w = 0; w < 16; w++) send_word(16'($urandom));
      idle(4);
      chk("desel_then_line", strobe_cnt - s0, 1);

      // random bytes with occasional FIFO backpressure
      for (int i = 0; i < 96 + 2 * $urandom_range(0, 8); i++) begin
         bus.fifo_full = ($urandom_range(0, 7) == 0);
         b = 8'($urandom);
         send_byte(b);
      end
      bus.fifo_full = 1'b0;
      idle(6);
      chk("rand_word_cnt", word_cnt, 4'(m_words.size()));
      chk("rand_ovf", overflow, exp_ovf);
      chk("lines_pending", exp_lines.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
